// File: rtl/if_bpu_pkg.sv
// Shared decode constants for the IF-stage branch prediction unit.
package if_bpu_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Bit positions inside the one-hot op_info vector produced by the decoder.
  localparam int OPI_JAL    = 0;
  localparam int OPI_JALR   = 1;
  localparam int OPI_BRANCH = 2;
  localparam int OPI_W      = 3;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_B    = 2'd2,
    IMM_J    = 2'd3
  } imm_type_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/if_bpu_if.sv
// Fetch/resolve bus between the fetch stage and the branch prediction unit.
interface if_bpu_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             if_valid_i;
  logic             if_stall_i;
  logic [XLEN-1:0]  if_pc_i;
  logic [31:0]      if_instr_i;
  logic             bpu_taken_o;
  logic [XLEN-1:0]  bpu_target_o;
  logic             ex_upd_valid_i;
  logic [XLEN-1:0]  ex_upd_pc_i;
  logic             ex_upd_taken_i;
  logic             ex_flush_i;
  logic [CNT_W-1:0] bpu_ras_cnt_o;

  modport master (
    output if_valid_i, if_stall_i, if_pc_i, if_instr_i,
    output ex_upd_valid_i, ex_upd_pc_i, ex_upd_taken_i, ex_flush_i,
    input  bpu_taken_o, bpu_target_o, bpu_ras_cnt_o
  );

  modport slave (
    input  if_valid_i, if_stall_i, if_pc_i, if_instr_i,
    input  ex_upd_valid_i, ex_upd_pc_i, ex_upd_taken_i, ex_flush_i,
    output bpu_taken_o, bpu_target_o, bpu_ras_cnt_o
  );
endinterface

// File: rtl/if_bpu_dec.sv
// Combinational mini-decode: control-flow class, rd/rs1 and sign-extended immediate.
module if_bpu_dec
  import if_bpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      i_instr,
  output logic [OPI_W-1:0] o_op_info,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [XLEN-1:0]  o_imm
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  imm_type_e  w_imm_type;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign o_rd  = i_instr[11:7];
  assign o_rs1 = i_instr[19:15];

  // Classify; funct3 values that are not legal for the opcode decode as non-control-flow.
  always_comb begin
    o_op_info  = '0;
    w_imm_type = IMM_NONE;
    case (w_opc)
      OPC_JAL: begin
        o_op_info[OPI_JAL] = 1'b1;
        w_imm_type         = IMM_J;
      end
      OPC_JALR: begin
        if (w_f3 == 3'b000) begin
          o_op_info[OPI_JALR] = 1'b1;
          w_imm_type          = IMM_I;
        end else begin
          o_op_info = '0;
        end
      end
      OPC_BRANCH: begin
        if ((w_f3 != 3'b010) && (w_f3 != 3'b011)) begin
          o_op_info[OPI_BRANCH] = 1'b1;
          w_imm_type            = IMM_B;
        end else begin
          o_op_info = '0;
        end
      end
      default: o_op_info = '0;
    endcase
  end

  always_comb begin
    case (w_imm_type)
      IMM_I:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      IMM_B:   o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J:   o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/if_bpu.sv
// IF-stage branch predictor: JAL, conditional branches (BTFN or 2-bit BHT) and RAS returns.
module if_bpu
  import if_bpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int RAS_DEPTH = 4,
  parameter int PRED_MODE = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_bpu_if.slave    bpu
);

  localparam int BHT_AW = $clog2(BHT_DEPTH);
  localparam int RAS_AW = $clog2(RAS_DEPTH);
  localparam int CNT_W  = RAS_AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [OPI_W-1:0]  w_op_info;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs1;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_seq_pc;
  logic [XLEN-1:0]   w_rel_tgt;
  logic [XLEN-1:0]   w_ras_top;
  logic              w_rd_link;
  logic              w_rs1_link;
  logic              w_br_taken;
  logic              w_commit;
  logic              w_taken;
  logic [XLEN-1:0]   w_target;
  logic              w_push;
  logic              w_pop;

  logic [XLEN-1:0]   r_ras [RAS_DEPTH];
  logic [RAS_AW-1:0] r_ras_ptr;
  logic [CNT_W-1:0]  r_ras_cnt;

  if_bpu_dec #(.XLEN(XLEN)) u_dec (
    .i_instr   (bpu.if_instr_i),
    .o_op_info (w_op_info),
    .o_rd      (w_rd),
    .o_rs1     (w_rs1),
    .o_imm     (w_imm)
  );

  assign w_seq_pc   = bpu.if_pc_i + XLEN'(4);
  assign w_rel_tgt  = bpu.if_pc_i + w_imm;
  assign w_ras_top  = r_ras[r_ras_ptr - RAS_AW'(1)];
  assign w_rd_link  = is_link(w_rd);
  assign w_rs1_link = is_link(w_rs1);
  assign w_commit   = bpu.if_valid_i & ~bpu.if_stall_i & ~bpu.ex_flush_i & ~rst_i;

  generate
    if (PRED_MODE == 1) begin : g_bht
      logic [1:0]        r_bht [BHT_DEPTH];
      logic [BHT_AW-1:0] w_rd_idx;
      logic [BHT_AW-1:0] w_wr_idx;
      logic              w_unused_ok;

      assign w_rd_idx    = bpu.if_pc_i[BHT_AW+1:2];
      assign w_wr_idx    = bpu.ex_upd_pc_i[BHT_AW+1:2];
      assign w_br_taken  = r_bht[w_rd_idx][1];
      assign w_unused_ok = ^{bpu.ex_upd_pc_i[XLEN-1:BHT_AW+2], bpu.ex_upd_pc_i[1:0]};

      // Saturating 2-bit counter training from EX; reads see the pre-edge value.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
        end else if (bpu.ex_upd_valid_i) begin
          if (bpu.ex_upd_taken_i && (r_bht[w_wr_idx] != 2'b11))
            r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'b01;
          else if (!bpu.ex_upd_taken_i && (r_bht[w_wr_idx] != 2'b00))
            r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'b01;
        end
      end
    end else begin : g_btfn
      logic w_unused_ok;
      assign w_br_taken  = w_imm[XLEN-1];
      assign w_unused_ok = ^{bpu.ex_upd_valid_i, bpu.ex_upd_pc_i, bpu.ex_upd_taken_i};
    end
  endgenerate

  // Prediction and RAS intent; push+pop together means "replace top" (coroutine swap).
  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    if (!rst_i && bpu.if_valid_i) begin
      if (w_op_info[OPI_JAL]) begin
        w_taken  = 1'b1;
        w_target = w_rel_tgt;
        w_push   = w_rd_link;
      end else if (w_op_info[OPI_BRANCH]) begin
        w_taken  = w_br_taken;
        w_target = w_rel_tgt;
      end else if (w_op_info[OPI_JALR]) begin
        if (w_rd_link && w_rs1_link && (w_rd != w_rs1)) begin
          w_push = 1'b1;
          if (r_ras_cnt != '0) begin
            w_taken  = 1'b1;
            w_target = w_ras_top;
            w_pop    = 1'b1;
          end else begin
            w_taken = 1'b0;
          end
        end else if (w_rd_link) begin
          w_push = 1'b1;
        end else if (w_rs1_link) begin
          if (r_ras_cnt != '0) begin
            w_taken  = 1'b1;
            w_target = w_ras_top;
            w_pop    = 1'b1;
          end else begin
            w_taken = 1'b0;
          end
        end else begin
          w_taken = 1'b0;
        end
      end else begin
        w_taken = 1'b0;
      end
    end else begin
      w_taken = 1'b0;
    end
  end

  // Circular RAS: push on full overwrites the oldest slot, count saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (w_commit) begin
      if (w_push && w_pop) begin
        r_ras[r_ras_ptr - RAS_AW'(1)] <= w_seq_pc;
      end else if (w_push) begin
        r_ras[r_ras_ptr] <= w_seq_pc;
        r_ras_ptr        <= r_ras_ptr + RAS_AW'(1);
        if (r_ras_cnt != CNT_MAX) r_ras_cnt <= r_ras_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_ras_ptr <= r_ras_ptr - RAS_AW'(1);
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end
    end
  end

  assign bpu.bpu_taken_o   = w_taken;
  assign bpu.bpu_target_o  = w_target;
  assign bpu.bpu_ras_cnt_o = r_ras_cnt;

endmodule
